i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_pkg.sv | 28 ++
 rtl/i2c_sync_edge.sv | 57 +++++
 rtl/i2c_target.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, bit-counter phases and address helpers.
// Used by both the I2C target and the existing I2C master.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RMACK,
    ST_WAIT
  } i2c_state_e;

  localparam logic [6:0] NACK_GENERAL_CALL = 7'h00;

  // Bit counter value 8 means "byte complete, ACK not yet driven"; 9 means "ACK on the bus".
  localparam logic [3:0] BIT_CNT_BYTE = 4'd8;
  localparam logic [3:0] BIT_CNT_ACK  = 4'd9;

  function automatic logic addr_match(input logic [6:0] addr, input logic [6:0] dev);
    return (addr == dev) && (addr != NACK_GENERAL_CALL);
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes SCL/SDA into the Clk domain and produces single-cycle SCL edge
// and START/STOP events. All flops preset to 1 so reset looks like an idle bus.
module i2c_sync_edge #(
  parameter int SyncStages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SyncStages-1:0] scl_sync_q, scl_sync_d;
  logic [SyncStages-1:0] sda_sync_q, sda_sync_d;
  logic                  scl_prev_q, scl_prev_d;
  logic                  sda_prev_q, sda_prev_d;
  logic                  scl_s;

  always_comb begin
    scl_sync_d    = scl_sync_q;
    sda_sync_d    = sda_sync_q;
    scl_sync_d[0] = scl_in;
    sda_sync_d[0] = sda_in;
    for (int i = 1; i < SyncStages; i++) begin
      scl_sync_d[i] = scl_sync_q[i-1];
      sda_sync_d[i] = sda_sync_q[i-1];
    end
    scl_s      = scl_sync_q[SyncStages-1];
    sda_s      = sda_sync_q[SyncStages-1];
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    scl_rise   = scl_s && !scl_prev_q;
    scl_fall   = !scl_s && scl_prev_q;
    // SDA may only change with SCL high (both samples) for a bus condition.
    start_det  = scl_s && scl_prev_q && sda_prev_q && !sda_s;
    stop_det   = scl_s && scl_prev_q && !sda_prev_q && sda_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing a byte-addressed register port: first write byte sets the
// pointer, further bytes write/read with auto-increment.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DevAddr    = 7'h42,
  parameter int         SyncStages = 2
) (
  input  logic       Clk,
  input  logic       ResetN,
  input  logic       SclIn,
  input  logic       SdaIn,
  output logic       SdaOe,
  output logic [7:0] RegAddr,
  output logic [7:0] RegWrData,
  output logic       RegWr,
  output logic       RegRd,
  input  logic [7:0] RegRdData,
  output logic       Busy
);

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wr_data_q, reg_wr_data_d;
  logic       sda_oe_q, sda_oe_d;
  logic       reg_wr_q, reg_wr_d;
  logic       reg_rd_q, reg_rd_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic [7:0] shift_in;
  logic       sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_sync_edge #(
    .SyncStages(SyncStages)
  ) u_sync_edge (
    .clk      (Clk),
    .rst_n    (ResetN),
    .scl_in   (SclIn),
    .sda_in   (SdaIn),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    reg_addr_d    = reg_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    sda_oe_d      = sda_oe_q;
    reg_wr_d      = 1'b0;
    reg_rd_d      = 1'b0;
    busy_d        = busy_q;
    rw_d          = rw_q;
    shift_in      = {shift_q[6:0], sda_s};

    if (reg_wr_q) begin
      reg_addr_d = reg_addr_q + 8'd1;
    end
    // Read data arrives the cycle after the strobe; put bit 7 on the bus right away.
    if (reg_rd_q && state_q == ST_RDATA) begin
      shift_d  = RegRdData;
      sda_oe_d = ~RegRdData[7];
    end

    case (state_q)
      ST_ADDR: begin
        if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            if (addr_match(shift_in[7:1], DevAddr)) begin
              state_d = ST_ADDR_ACK;
              rw_d    = shift_in[0];
              busy_d  = 1'b1;
            end else begin
              state_d = ST_WAIT;
              busy_d  = 1'b0;
            end
          end
        end
      end
      ST_PTR: begin
        if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            reg_addr_d = shift_in;
            state_d    = ST_PTR_ACK;
          end
        end
      end
      ST_WDATA: begin
        if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            reg_wr_d      = 1'b1;
            reg_wr_data_d = shift_in;
            state_d       = ST_WDATA_ACK;
          end
        end
      end
      ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
        if (scl_fall) begin
          if (bit_cnt_q == BIT_CNT_BYTE) begin
            sda_oe_d  = 1'b1;
            bit_cnt_d = BIT_CNT_ACK;
          end else if (bit_cnt_q == BIT_CNT_ACK) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if (state_q == ST_ADDR_ACK && rw_q) begin
              state_d  = ST_RDATA;
              reg_rd_d = 1'b1;
            end else if (state_q == ST_ADDR_ACK) begin
              state_d = ST_PTR;
            end else begin
              state_d = ST_WDATA;
            end
          end
        end
      end
      ST_RDATA: begin
        if (scl_rise && bit_cnt_q != BIT_CNT_BYTE) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        // Rotate rather than shift so the whole byte stays resident in the register.
        if (scl_fall) begin
          if (bit_cnt_q == BIT_CNT_BYTE) begin
            state_d   = ST_RMACK;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
          end else begin
            shift_d  = {shift_q[6:0], shift_q[7]};
            sda_oe_d = ~shift_q[6];
          end
        end
      end
      ST_RMACK: begin
        if (scl_rise && bit_cnt_q == 4'd0) begin
          if (!sda_s) begin
            reg_addr_d = reg_addr_q + 8'd1;
            bit_cnt_d  = 4'd1;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (scl_fall && bit_cnt_q == 4'd1) begin
          reg_rd_d  = 1'b1;
          state_d   = ST_RDATA;
          bit_cnt_d = '0;
        end
      end
      default: ;
    endcase

    // Bus conditions override any bit event seen in the same cycle.
    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      reg_wr_d  = 1'b0;
      reg_rd_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      reg_wr_d  = 1'b0;
      reg_rd_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      reg_addr_q    <= '0;
      reg_wr_data_q <= '0;
      sda_oe_q      <= 1'b0;
      reg_wr_q      <= 1'b0;
      reg_rd_q      <= 1'b0;
      busy_q        <= 1'b0;
      rw_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      sda_oe_q      <= sda_oe_d;
      reg_wr_q      <= reg_wr_d;
      reg_rd_q      <= reg_rd_d;
      busy_q        <= busy_d;
      rw_q          <= rw_d;
    end
  end

  assign SdaOe     = sda_oe_q;
  assign RegAddr   = reg_addr_q;
  assign RegWrData = reg_wr_data_q;
  assign RegWr     = reg_wr_q;
  assign RegRd     = reg_rd_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-level I2C master drives an open-drain bus while a
// register-file model predicts acks, write strobes, read bytes and the pointer.
module tb_i2c_target;

  localparam logic [6:0] DEV = 7'h42;
  localparam int         Q   = 5;

  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  ptr;
    int          ndata;
    logic [31:0] data;
    logic        exp_ack;
    logic [7:0]  exp_end_addr;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       scl_m;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rd_data;
  logic       busy;

  logic [7:0]  rd_mem [256];
  logic [15:0] wr_log [$];
  int          rd_count;
  int          oe_count;
  int          total;
  int          bad;
  int          model_ptr;
  vec_t        vecs [5];

  assign sda_bus     = sda_m & ~sda_oe;
  assign reg_rd_data = rd_mem[reg_addr];

  i2c_target #(
    .DevAddr   (DEV),
    .SyncStages(2)
  ) dut (
    .Clk      (clk),
    .ResetN   (reset_n),
    .SclIn    (scl_m),
    .SdaIn    (sda_bus),
    .SdaOe    (sda_oe),
    .RegAddr  (reg_addr),
    .RegWrData(reg_wr_data),
    .RegWr    (reg_wr),
    .RegRd    (reg_rd),
    .RegRdData(reg_rd_data),
    .Busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive monitor of the register port and of SDA drive.
  initial begin
    rd_count = 0;
    oe_count = 0;
  end
  always @(negedge clk) begin
    if (reg_wr) wr_log.push_back({reg_addr, reg_wr_data});
    if (reg_rd) rd_count++;
    if (sda_oe) oe_count++;
  end

  function automatic logic model_ack(input logic [6:0] a);
    return (a == DEV) && (a != 7'h00);
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(2 * Q);
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    b = sda_bus;
    wait_clk(Q);
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    sda_m = 1'b1;
    wait_clk(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic bit_v;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(bit_v);
    ack = ~bit_v;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] b);
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(bit_v);
      b[i] = bit_v;
    end
    send_bit(~master_ack);
    sda_m = 1'b1;
  endtask

  // One complete write transaction: address, pointer, data bytes, STOP.
  task automatic apply_stimulus(input vec_t v);
    logic        ack;
    logic [7:0]  d;
    logic [15:0] exp_q [$];
    int          wr_base;
    int          rd_base;
    int          oe_base;
    logic        acked;
    wr_base = wr_log.size();
    rd_base = rd_count;
    oe_base = oe_count;
    acked   = model_ack(v.addr);
    i2c_start();
    write_byte({v.addr, 1'b0}, ack);
    check_output("addr_ack", ack, v.exp_ack);
    check_output("busy_in_xfer", busy, acked);
    write_byte(v.ptr, ack);
    check_output("ptr_ack", ack, v.exp_ack);
    if (acked) model_ptr = v.ptr;
    for (int i = 0; i < v.ndata; i++) begin
      d = v.data[8*i +: 8];
      write_byte(d, ack);
      check_output("data_ack", ack, v.exp_ack);
      if (acked) begin
        exp_q.push_back({model_ptr[7:0], d});
        model_ptr = (model_ptr + 1) % 256;
      end
    end
    i2c_stop();
    check_output("busy_after_stop", busy, 1'b0);
    check_output("wr_count", wr_log.size() - wr_base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (wr_base + i < wr_log.size()) check_output("wr_entry", wr_log[wr_base + i], exp_q[i]);
    end
    check_output("reg_addr_end", reg_addr, v.exp_end_addr);
    check_output("reg_addr_model", reg_addr, model_ptr);
    check_output("no_rd", rd_count - rd_base, 0);
    if (!acked) check_output("silent", oe_count - oe_base, 0);
  endtask

  // Set pointer, repeated START, read n bytes (ACK all but the last).
  task automatic do_read(input logic [7:0] ptr, input int n);
    logic       ack;
    logic [7:0] b;
    int         rd_base;
    rd_base = rd_count;
    i2c_start();
    write_byte({DEV, 1'b0}, ack);
    check_output("rd_addrw_ack", ack, 1'b1);
    write_byte(ptr, ack);
    check_output("rd_ptr_ack", ack, 1'b1);
    model_ptr = ptr;
    i2c_start();
    write_byte({DEV, 1'b1}, ack);
    check_output("rd_addrr_ack", ack, 1'b1);
    for (int i = 0; i < n; i++) begin
      read_byte(i < n - 1, b);
      check_output("rd_data", b, rd_mem[(ptr + i) % 256]);
      if (i < n - 1) model_ptr = (model_ptr + 1) % 256;
    end
    wait_clk(2 * Q);
    check_output("sda_released", sda_oe, 1'b0);
    check_output("rd_pulses", rd_count - rd_base, n);
    i2c_stop();
    check_output("rd_busy_end", busy, 1'b0);
    check_output("rd_reg_addr", reg_addr, model_ptr);
  endtask

  initial begin
    logic        ack;
    logic        bit_v;
    logic [7:0]  ptr;
    int          n;
    int          wr_base;
    vec_t        v;
    total     = 0;
    bad       = 0;
    model_ptr = 0;
    reset_n   = 1'b0;
    scl_m     = 1'b1;
    sda_m     = 1'b1;
    for (int i = 0; i < 256; i++) rd_mem[i] = 8'($urandom);
    rd_mem[8'h20] = 8'h3C;
    rd_mem[8'h21] = 8'hC3;
    rd_mem[8'h60] = 8'h00;

    vecs[0] = '{addr: 7'h42, ptr: 8'h10, ndata: 2, data: 32'h0000_5AA5, exp_ack: 1'b1, exp_end_addr: 8'h12};
    vecs[1] = '{addr: 7'h43, ptr: 8'h00, ndata: 1, data: 32'h0000_0011, exp_ack: 1'b0, exp_end_addr: 8'h12};
    vecs[2] = '{addr: 7'h42, ptr: 8'hFF, ndata: 2, data: 32'h0000_0201, exp_ack: 1'b1, exp_end_addr: 8'h01};
    vecs[3] = '{addr: 7'h00, ptr: 8'h33, ndata: 1, data: 32'h0000_0044, exp_ack: 1'b0, exp_end_addr: 8'h01};
    vecs[4] = '{addr: 7'h42, ptr: 8'h7E, ndata: 3, data: 32'h0007_0809, exp_ack: 1'b1, exp_end_addr: 8'h81};

    $display("[TB] starting i2c_target bench");
    wait_clk(3);
    check_output("rst_sda_oe", sda_oe, 1'b0);
    check_output("rst_reg_addr", reg_addr, 8'h00);
    check_output("rst_wr_data", reg_wr_data, 8'h00);
    check_output("rst_reg_wr", reg_wr, 1'b0);
    check_output("rst_reg_rd", reg_rd, 1'b0);
    check_output("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    wait_clk(5);

    for (int i = 0; i < 5; i++) apply_stimulus(vecs[i]);

    do_read(8'h20, 2);

    // STOP after four data bits: no write, back to idle.
    wr_base = wr_log.size();
    i2c_start();
    write_byte({DEV, 1'b0}, ack);
    write_byte(8'h50, ack);
    model_ptr = 8'h50;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    i2c_stop();
    check_output("stop_mid_no_wr", wr_log.size() - wr_base, 0);
    check_output("stop_mid_busy", busy, 1'b0);
    check_output("stop_mid_addr", reg_addr, model_ptr);

    // Reset pulse while the target drives a read data bit.
    i2c_start();
    write_byte({DEV, 1'b0}, ack);
    write_byte(8'h60, ack);
    i2c_start();
    write_byte({DEV, 1'b1}, ack);
    for (int i = 0; i < 3; i++) recv_bit(bit_v);
    sda_m = 1'b1;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    check_output("oe_before_reset", sda_oe, 1'b1);
    reset_n = 1'b0;
    #1;
    check_output("oe_in_reset", sda_oe, 1'b0);
    check_output("busy_in_reset", busy, 1'b0);
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(Q);
    scl_m = 1'b0;
    wait_clk(Q);
    n = oe_count;
    for (int i = 0; i < 4; i++) recv_bit(bit_v);
    send_bit(1'b0);
    for (int i = 0; i < 9; i++) recv_bit(bit_v);
    check_output("silent_after_reset", oe_count - n, 0);
    check_output("addr_after_reset", reg_addr, 8'h00);
    i2c_stop();
    model_ptr = 0;
    i2c_start();
    write_byte({DEV, 1'b0}, ack);
    check_output("ack_after_reset", ack, 1'b1);
    write_byte(8'h05, ack);
    i2c_stop();
    model_ptr = 8'h05;
    check_output("ptr_after_reset", reg_addr, model_ptr);

    // Randomized write transactions against the model.
    for (int k = 0; k < 6; k++) begin
      v.addr  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : DEV;
      v.ptr   = 8'($urandom);
      v.ndata = $urandom_range(1, 3);
      v.data  = $urandom;
      v.exp_ack = model_ack(v.addr);
      v.exp_end_addr = v.exp_ack ? 8'((v.ptr + v.ndata) % 256) : model_ptr[7:0];
      apply_stimulus(v);
    end

    // Randomized reads, including pointer wrap.
    do_read(8'hFE, 3);
    for (int k = 0; k < 3; k++) begin
      ptr = 8'($urandom);
      n   = $urandom_range(1, 3);
      do_read(ptr, n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
